t03_load_store_unit: RTL and testbench
======================================

// Module: t03_load_store_unit
// PURPOSE
//  Memory stage between the ALU and the register file. Decodes load/store instructions
//  and forms the word address, byte-lane mask and lane-shifted write data from
//  result_ALU and read_data2. Runs a req/ack handshake with the data cache/bus and
//  stalls the core while the access is outstanding. Returns sign/zero-extended load
//  data on data_out, which the register file consumes through its memToReg path.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles without ack before the access aborts with bus_err
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  instruction   in   32  current instruction; opcode[6:0] and funct3[14:12] are used
//  result_ALU    in   32  effective byte address
//  read_data2    in   32  store source (rs2)
//  mem_ack       in   1   bus/cache completion strobe; valid only while BUSY
//  mem_rdata     in   32  read word; sampled on the mem_ack cycle
//  mem_read      out  1   read request; held until ack
//  mem_write     out  1   write request; held until ack
//  mem_addr      out  32  {result_ALU[31:2],2'b00}
//  mem_wdata     out  32  store data shifted to its byte lane
//  mem_sel       out  4   byte-lane enables
//  data_out      out  32  extended load result; holds until the next load completes
//  freeze        out  1   stall the PC and regwrite while an access is pending
//  misaligned    out  1   1-cycle pulse in DONE for a misaligned access
//  bus_err       out  1   1-cycle pulse in DONE on timeout
// BEHAVIOUR
//  - Registered reset values: state=IDLE, data_out=0, counter=0, misaligned=0, bus_err=0.
//    Request outputs are forced low by state, so mem_read=mem_write=0 and mem_sel=0 after reset.
//  - Memory op: opcode 0000011 (LB/LH/LW/LBU/LHU = f3 000/001/010/100/101) or
//    0100011 (SB/SH/SW = f3 000/001/010). Any other opcode or funct3 is not a memory op.
//  - freeze = memop && state!=DONE (combinational). It is 0 in DONE, so the core advances
//    on the DONE edge and the same instruction is not issued twice.
//  - IDLE: on an aligned memop -> BUSY and clear the counter. On a misaligned memop
//    (H with addr[0]=1, W with addr[1:0]!=0) -> DONE with misaligned=1 and no bus request.
//  - BUSY: drive mem_read or mem_write, plus mem_addr, mem_sel and mem_wdata, every cycle.
//    An ack may arrive on the first BUSY cycle.
//    * ack on a load -> register the extended data_out and go to DONE.
//    * ack on a store -> go to DONE; data_out is unchanged.
//    * counter==TIMEOUT_CYCLES-1 with no ack -> DONE with bus_err=1 and data_out=0 for loads.
//  - DONE: one cycle, then IDLE unconditionally.
//  - mem_ack outside BUSY is ignored.
//  - Lane rules, off=addr[1:0]:
//    * B: sel=1<<off, wdata={4{rs2[7:0]}}.
//    * H: sel=0011<<off, wdata={2{rs2[15:0]}}.
//    * W: sel=1111, wdata=rs2.
//  - Load extract: byte/half taken from mem_rdata at off*8. LB/LH sign-extend; LBU/LHU zero-extend.
//  - reset mid-BUSY: requests drop on the next edge, state=IDLE, and the pending load
//    result is discarded.
// STRUCTURE
//  - Package t03_lsu_pkg: lsu_state_t enum {IDLE,BUSY,DONE}, OPC_LOAD/OPC_STORE, F3_* funct3 constants.
//  - Sub-module t03_load_extend (combinational): mem_rdata, off, funct3 -> 32-bit extended word.
//  - Top level: FSM, timeout counter, lane/mask generation.
// TESTING
//  - LW addr 0x100, ack 2 cycles after BUSY entry with rdata 0xDEADBEEF:
//    mem_read held 2 cycles, sel=1111; data_out=0xDEADBEEF in DONE; freeze high until DONE.
//  - LB addr 0x103, rdata 0x80FFFFFF: data_out=0xFFFFFF80. LBU, same inputs: data_out=0x00000080.
//  - SH addr 0x202, rs2=0x1234BEEF:
//    mem_write=1, sel=1100, wdata=0xBEEFBEEF, addr=0x200; data_out unchanged.
//  - LW addr 0x102: no mem_read at any cycle; misaligned pulses for 1 cycle; freeze high for 1 cycle.
//  - TIMEOUT_CYCLES=4, LW with no ack:
//    mem_read high exactly 4 cycles, then bus_err pulse, data_out=0, return to IDLE.
//  - reset asserted on the 2nd BUSY cycle: mem_read=0 next cycle, state=IDLE; a late ack is ignored.

Source files
------------

// File: rtl/t03_lsu_pkg.sv
// Shared types and decode constants for the load/store unit.
package t03_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/t03_load_extend.sv
// Pulls the addressed byte/half out of a read word and sign- or zero-extends it.
module t03_load_extend
  import t03_lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data_ext
);

  logic [31:0] shifted;

  assign shifted = mem_rdata >> {off, 3'b000};

  always_comb begin
    data_ext = mem_rdata;
    case (funct3)
      F3_B:    data_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_ext = {24'b0, shifted[7:0]};
      F3_HU:   data_ext = {16'b0, shifted[15:0]};
      default: data_ext = mem_rdata;
    endcase
  end

endmodule

// File: rtl/t03_load_store_unit.sv
// Memory stage: decodes loads/stores, forms lane mask/data, runs the bus handshake.
//  state | meaning
//  IDLE  | waiting for a memory op; misaligned ops skip straight to DONE
//  BUSY  | request on the bus, waiting for ack or timeout
//  DONE  | one-cycle completion; freeze released so the core advances
module t03_load_store_unit
  import t03_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] result_ALU,
  input  logic [31:0] read_data2,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic [31:0] data_out,
  output logic        freeze,
  output logic        misaligned,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, state_nxt;
  logic [CW-1:0] counter, counter_nxt;
  logic [31:0] data_nxt, load_word, wdata_raw;
  logic [3:0]  sel_raw;
  logic        mis_nxt, err_nxt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        is_load, is_store, memop, misal, busy;
  logic        unused_bits;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign off      = result_ALU[1:0];
  assign is_load  = (opcode == OPC_LOAD) &&
                    (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign is_store = (opcode == OPC_STORE) && (funct3 inside {F3_B, F3_H, F3_W});
  assign memop    = is_load || is_store;
  assign misal    = ((funct3[1:0] == 2'b01) && off[0]) ||
                    ((funct3[1:0] == 2'b10) && (off != 2'b00));
  assign busy     = (state == BUSY);
  assign unused_bits = ^{instruction[31:15], instruction[11:7]};

  t03_load_extend u_extend (
    .mem_rdata (mem_rdata),
    .off       (off),
    .funct3    (funct3),
    .data_ext  (load_word)
  );

  // funct3[1:0] carries the access size for both loads and stores
  always_comb begin
    sel_raw   = 4'b1111;
    wdata_raw = read_data2;
    case (funct3[1:0])
      2'b00: begin
        sel_raw   = 4'b0001 << off;
        wdata_raw = {4{read_data2[7:0]}};
      end
      2'b01: begin
        sel_raw   = 4'b0011 << off;
        wdata_raw = {2{read_data2[15:0]}};
      end
      default: begin
        sel_raw   = 4'b1111;
        wdata_raw = read_data2;
      end
    endcase
  end

  assign mem_read  = busy && is_load;
  assign mem_write = busy && is_store;
  assign mem_sel   = busy ? sel_raw : 4'b0000;
  assign mem_addr  = {result_ALU[31:2], 2'b00};
  assign mem_wdata = wdata_raw;
  assign freeze    = memop && (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      data_out   <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      data_out   <= data_nxt;
      misaligned <= mis_nxt;
      bus_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    data_nxt    = data_out;
    mis_nxt     = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          if (misal) begin
            state_nxt = DONE;
            mis_nxt   = 1'b1;
          end else begin
            state_nxt   = BUSY;
            counter_nxt = '0;
          end
        end
      end
      BUSY: begin
        // ack wins over a timeout landing on the same cycle
        if (mem_ack) begin
          state_nxt = DONE;
          if (is_load) data_nxt = load_word;
        end else if (counter == CNT_LAST) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
          if (is_load) data_nxt = '0;
        end else begin
          counter_nxt = counter + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_t03_load_store_unit.sv
// Randomized bench for t03_load_store_unit against a transaction-level reference model.
module tb_t03_load_store_unit;

  localparam int TO = 4;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, result_ALU, read_data2, mem_rdata;
  logic        mem_ack;
  logic        mem_read, mem_write, freeze, misaligned, bus_err;
  logic [31:0] mem_addr, mem_wdata, data_out;
  logic [3:0]  mem_sel;

  t03_load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .result_ALU(result_ALU),
    .read_data2(read_data2), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .data_out(data_out),
    .freeze(freeze), .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 0;

  logic        exp_read, exp_write, exp_freeze, exp_mis, exp_err, exp_busy;
  logic [3:0]  exp_sel;
  logic [31:0] exp_addr, exp_wdata, exp_data;
  logic [31:0] model_data;

  int rd_cnt, frz_cnt, mis_cnt, err_cnt;
  logic [31:0] last_wdata;
  logic [3:0]  last_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("mem_read", 32'(mem_read), 32'(exp_read));
      chk("mem_write", 32'(mem_write), 32'(exp_write));
      chk("mem_sel", 32'(mem_sel), 32'(exp_sel));
      chk("freeze", 32'(freeze), 32'(exp_freeze));
      chk("misaligned", 32'(misaligned), 32'(exp_mis));
      chk("bus_err", 32'(bus_err), 32'(exp_err));
      chk("data_out", data_out, exp_data);
      if (exp_busy) begin
        chk("mem_addr", mem_addr, exp_addr);
        if (exp_write) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (mem_read) rd_cnt++;
      if (freeze) frz_cnt++;
      if (misaligned) mis_cnt++;
      if (bus_err) err_cnt++;
      if (mem_write) begin
        last_wdata = mem_wdata;
        last_sel   = mem_sel;
      end
    end
  end

  function automatic logic [31:0] make_ins(input logic [6:0] opc, input logic [2:0] f3);
    return {17'b0, f3, 5'b0, opc};
  endfunction

  function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'(1 << off);
      2'b01:   return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'b00:   return (rs2 & 32'hFF) * 32'h01010101;
      2'b01:   return (rs2 & 32'hFFFF) * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [31:0] w, v;
    w = rd >> (8 * int'(off));
    case (f3)
      3'd0: begin v = w & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = w & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd4: v = w & 32'hFF;
      3'd5: v = w & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic set_idle_exp(input logic frz);
    exp_read = 0; exp_write = 0; exp_sel = 4'h0; exp_busy = 0;
    exp_freeze = frz; exp_mis = 0; exp_err = 0; exp_data = model_data;
  endtask

  // ack_at: BUSY cycle (1-based) carrying mem_ack; larger than TO means never
  task automatic run_txn(input logic [31:0] ins, input logic [31:0] addr,
                         input logic [31:0] rs2, input int ack_at, input logic [31:0] rdata);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [1:0] off;
    bit ld, st, mis, to;
    opc = ins[6:0];
    f3  = ins[14:12];
    off = addr[1:0];
    ld  = (opc == LD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st  = (opc == ST) && (f3 <= 3'd2);
    mis = ((f3[1:0] == 2'b01) && (off % 2 != 0)) || ((f3[1:0] == 2'b10) && (off != 0));
    to  = 0;
    rd_cnt = 0; frz_cnt = 0; mis_cnt = 0; err_cnt = 0;
    instruction = ins; result_ALU = addr; read_data2 = rs2;
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    set_idle_exp(ld || st);
    @(posedge clk); #1;
    if (!(ld || st)) return;
    if (mis) begin
      set_idle_exp(0);
      exp_mis = 1;
      mem_ack = 1'($urandom % 2);
      @(posedge clk); #1;
      return;
    end
    for (int k = 1; k <= TO; k++) begin
      exp_read = ld; exp_write = st; exp_busy = 1;
      exp_sel = m_sel(f3, off); exp_addr = addr & 32'hFFFFFFFC;
      exp_wdata = m_wdata(f3, rs2); exp_freeze = 1; exp_mis = 0; exp_err = 0;
      exp_data = model_data;
      mem_ack = (k == ack_at);
      mem_rdata = (k == ack_at) ? rdata : $urandom;
      @(posedge clk); #1;
      if (k == ack_at) begin
        if (ld) model_data = m_load(f3, off, rdata);
        break;
      end
      if (k == TO) begin
        to = 1;
        if (ld) model_data = 32'h0;
      end
    end
    set_idle_exp(0);
    exp_err = to;
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3;
    logic [6:0] opc;
    logic [31:0] a;
    int r;
    reset = 1; instruction = NOP; result_ALU = 0; read_data2 = 0;
    mem_ack = 0; mem_rdata = 0;
    model_data = 0;
    set_idle_exp(0);
    repeat (2) @(posedge clk);
    #1 check_en = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("reset_data_out", data_out, 32'h0);

    run_txn(make_ins(LD, 3'd2), 32'h100, 32'h0, 2, 32'hDEADBEEF);
    chk("lw_data", data_out, 32'hDEADBEEF);
    chk("lw_read_cycles", 32'(rd_cnt), 32'd2);
    chk("lw_freeze_cycles", 32'(frz_cnt), 32'd3);

    run_txn(make_ins(LD, 3'd0), 32'h103, 32'h0, 1, 32'h80FFFFFF);
    chk("lb_data", data_out, 32'hFFFFFF80);
    run_txn(make_ins(LD, 3'd4), 32'h103, 32'h0, 1, 32'h80FFFFFF);
    chk("lbu_data", data_out, 32'h00000080);

    run_txn(make_ins(ST, 3'd1), 32'h202, 32'h1234BEEF, 2, 32'h0);
    chk("sh_wdata", last_wdata, 32'hBEEFBEEF);
    chk("sh_sel", 32'(last_sel), 32'hC);
    chk("sh_data_kept", data_out, 32'h00000080);

    run_txn(make_ins(LD, 3'd2), 32'h102, 32'h0, 1, 32'h0);
    chk("mis_read_cycles", 32'(rd_cnt), 32'd0);
    chk("mis_pulses", 32'(mis_cnt), 32'd1);
    chk("mis_freeze_cycles", 32'(frz_cnt), 32'd1);
    chk("mis_data_kept", data_out, 32'h00000080);

    run_txn(make_ins(LD, 3'd2), 32'h104, 32'h0, TO + 1, 32'h0);
    chk("to_read_cycles", 32'(rd_cnt), 32'(TO));
    chk("to_err_pulses", 32'(err_cnt), 32'd1);
    chk("to_data", data_out, 32'h0);

    // reset on the second BUSY cycle, then a late ack while reset still held
    run_txn(make_ins(LD, 3'd2), 32'h300, 32'h0, 1, 32'h13572468);
    rd_cnt = 0;
    instruction = make_ins(LD, 3'd2); result_ALU = 32'h300;
    mem_ack = 0;
    set_idle_exp(1);
    @(posedge clk); #1;
    exp_read = 1; exp_busy = 1; exp_sel = 4'hF; exp_addr = 32'h300;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    model_data = 0;
    set_idle_exp(1);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    reset = 0; instruction = NOP; mem_ack = 0;
    set_idle_exp(0);
    @(posedge clk); #1;
    chk("rst_read_cycles", 32'(rd_cnt), 32'd2);
    chk("rst_data", data_out, 32'h0);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        opc = LD;
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else if (r <= 7) begin
        opc = ST; f3 = 3'($urandom_range(0, 2));
      end else if (r == 8) begin
        opc = ($urandom % 2) ? LD : ST;
        f3 = ($urandom % 2) ? 3'd3 : 3'($urandom_range(6, 7));
      end else begin
        opc = 7'($urandom); f3 = 3'($urandom);
      end
      a = $urandom;
      if ($urandom % 2) a[1:0] = 2'b00;
      run_txn(make_ins(opc, f3), a, $urandom, $urandom_range(1, TO + 1), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
